// File: rtl/uart_calc_command_parser_pkg.sv
// Shared types and ASCII constants for the UART calculator command parser.
package uart_calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_OP,
        CLS_SPACE,
        CLS_TERM,
        CLS_OTHER
    } byte_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPA,
        ST_OPB_START,
        ST_OPB,
        ST_HOLD,
        ST_DISCARD
    } parse_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

endpackage

// File: rtl/uart_calc_command_parser_if.sv
// Byte stream in, parsed command out. The master is the byte source / calculator side.
interface uart_calc_command_parser_if #(
    parameter int WIDTH = 16
);
    import uart_calc_pkg::*;

    logic [7:0]       byte_data;
    logic             byte_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    op_t              opcode;
    // A command transfers on every rising edge where cmd_valid && cmd_ready; once raised,
    // cmd_valid and the operand/opcode fields stay stable until that transfer happens.
    logic             cmd_valid;
    logic             cmd_ready;
    logic             error;
    logic             busy;
    parse_state_t     dbg_state;

    modport master (
        output byte_data, byte_ready, cmd_ready,
        input  operand_a, operand_b, opcode, cmd_valid, error, busy, dbg_state
    );

    modport slave (
        input  byte_data, byte_ready, cmd_ready,
        output operand_a, operand_b, opcode, cmd_valid, error, busy, dbg_state
    );

endinterface

// File: rtl/uart_calc_ascii_classifier.sv
// Combinational split of one ASCII byte into class, digit value and operator.
module uart_calc_ascii_classifier
    import uart_calc_pkg::*;
(
    input  logic [7:0]  i_byte,
    output byte_class_t o_class,
    output logic [3:0]  o_digit,
    output op_t         o_op
);

    always_comb begin
        o_class = CLS_OTHER;
        o_digit = 4'd0;
        o_op    = OP_ADD;
        if (i_byte >= ASCII_0 && i_byte <= ASCII_9) begin
            o_class = CLS_DIGIT;
            o_digit = 4'(i_byte - ASCII_0);
        end else begin
            case (i_byte)
                ASCII_PLUS:  begin o_class = CLS_OP; o_op = OP_ADD; end
                ASCII_MINUS: begin o_class = CLS_OP; o_op = OP_SUB; end
                ASCII_STAR:  begin o_class = CLS_OP; o_op = OP_MUL; end
                ASCII_SLASH: begin o_class = CLS_OP; o_op = OP_DIV; end
                ASCII_SPACE: o_class = CLS_SPACE;
                ASCII_CR,
                ASCII_LF:    o_class = CLS_TERM;
                default:     o_class = CLS_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/uart_calc_command_parser.sv
// Parses "<A><op><B><CR|LF>" byte streams into one command per line; bad lines flag error.
module uart_calc_command_parser
    import uart_calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input logic                       clock,
    input logic                       reset,
    uart_calc_command_parser_if.slave bus
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    parse_state_t     r_state;
    parse_state_t     w_state_next;
    logic [WIDTH-1:0] r_operand_a;
    logic [WIDTH-1:0] r_operand_b;
    op_t              r_opcode;
    logic [CW-1:0]    r_count;
    logic             r_error;

    byte_class_t      w_class;
    logic [3:0]       w_digit;
    op_t              w_op;
    logic             w_is_digit, w_is_op, w_is_term, w_is_other, w_digit_full;
    logic             w_err_set, w_load_a, w_acc_a, w_load_b, w_acc_b, w_latch_op;
    logic             w_cmd_valid, w_busy;
    logic [WIDTH-1:0] w_digit_ext, w_acc_a_val, w_acc_b_val;

    uart_calc_ascii_classifier u_classifier (
        .i_byte  (bus.byte_data),
        .o_class (w_class),
        .o_digit (w_digit),
        .o_op    (w_op)
    );

    // Spaces fall through every class strobe, so they are ignored in all states.
    assign w_is_digit   = bus.byte_ready && (w_class == CLS_DIGIT);
    assign w_is_op      = bus.byte_ready && (w_class == CLS_OP);
    assign w_is_term    = bus.byte_ready && (w_class == CLS_TERM);
    assign w_is_other   = bus.byte_ready && (w_class == CLS_OTHER);
    assign w_digit_full = (r_count == CW'(MAX_DIGITS));
    assign w_digit_ext  = WIDTH'(w_digit);
    assign w_acc_a_val  = (r_operand_a << 3) + (r_operand_a << 1) + w_digit_ext;
    assign w_acc_b_val  = (r_operand_b << 3) + (r_operand_b << 1) + w_digit_ext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_digit)                  w_state_next = ST_OPA;
                else if (w_is_op || w_is_other)  w_state_next = ST_DISCARD;
            end
            ST_OPA: begin
                if (w_is_digit && w_digit_full)  w_state_next = ST_DISCARD;
                else if (w_is_op)                w_state_next = ST_OPB_START;
                else if (w_is_term)              w_state_next = ST_IDLE;
                else if (w_is_other)             w_state_next = ST_DISCARD;
            end
            ST_OPB_START: begin
                if (w_is_digit)                  w_state_next = ST_OPB;
                else if (w_is_term)              w_state_next = ST_IDLE;
                else if (w_is_op || w_is_other)  w_state_next = ST_DISCARD;
            end
            ST_OPB: begin
                if (w_is_digit && w_digit_full)  w_state_next = ST_DISCARD;
                else if (w_is_term)              w_state_next = ST_HOLD;
                else if (w_is_op || w_is_other)  w_state_next = ST_DISCARD;
            end
            ST_HOLD:    if (bus.cmd_ready) w_state_next = ST_IDLE;
            ST_DISCARD: if (w_is_term)     w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_valid = (r_state == ST_HOLD);
        w_busy      = (r_state != ST_IDLE);
        w_err_set   = 1'b0;
        w_load_a    = 1'b0;
        w_acc_a     = 1'b0;
        w_load_b    = 1'b0;
        w_acc_b     = 1'b0;
        w_latch_op  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_a  = w_is_digit;
                w_err_set = w_is_op || w_is_other;
            end
            ST_OPA: begin
                w_acc_a    = w_is_digit && !w_digit_full;
                w_latch_op = w_is_op;
                w_err_set  = (w_is_digit && w_digit_full) || w_is_term || w_is_other;
            end
            ST_OPB_START: begin
                w_load_b  = w_is_digit;
                w_err_set = w_is_term || w_is_op || w_is_other;
            end
            ST_OPB: begin
                w_acc_b   = w_is_digit && !w_digit_full;
                w_err_set = (w_is_digit && w_digit_full) || w_is_op || w_is_other;
            end
            // Any byte landing while a command is parked is lost, handshake cycle included.
            ST_HOLD:  w_err_set = bus.byte_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= OP_ADD;
            r_count     <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= w_err_set;
            if (w_load_a)      r_operand_a <= w_digit_ext;
            else if (w_acc_a)  r_operand_a <= w_acc_a_val;
            if (w_load_b)      r_operand_b <= w_digit_ext;
            else if (w_acc_b)  r_operand_b <= w_acc_b_val;
            if (w_latch_op)    r_opcode <= w_op;
            if (w_load_a || w_load_b)     r_count <= CW'(1);
            else if (w_acc_a || w_acc_b)  r_count <= r_count + CW'(1);
        end
    end

    assign bus.operand_a = r_operand_a;
    assign bus.operand_b = r_operand_b;
    assign bus.opcode    = r_opcode;
    assign bus.cmd_valid = w_cmd_valid;
    assign bus.error     = r_error;
    assign bus.busy      = w_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_calc_command_parser.sv
// Directed bench for the command parser with a command scoreboard and pulse counters.
module tb_uart_calc_command_parser;
    import uart_calc_pkg::*;

    localparam int W = 34;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   valid_cycles = 0;
    int   hs_cnt = 0;
    int   base_e, base_v, base_h;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_cmd;
    logic [W-1:0] exp_cmd;
    logic         prev_valid = 1'b0;

    uart_calc_command_parser_if #(.WIDTH(16)) bus ();

    uart_calc_command_parser #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int a, input int b, input op_t op);
        logic [15:0] a16, b16;
        a16 = a[15:0];
        b16 = b[15:0];
        return {a16, b16, op};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1;
        bus.byte_data  = b;
        bus.byte_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.byte_ready = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic mark();
        base_e = err_pulses;
        base_v = valid_cycles;
        base_h = hs_cnt;
    endtask

    // Monitor: counts pulses, pops the scoreboard on each handshake, checks hold stability.
    always @(negedge clock) begin
        if (bus.error) err_pulses++;
        if (bus.cmd_valid) begin
            valid_cycles++;
            if (prev_valid)
                chk("hold_stable", {bus.operand_a, bus.operand_b, bus.opcode}, prev_cmd);
            if (bus.cmd_ready) begin
                hs_cnt++;
                chk("cmd_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_cmd = exp_q.pop_front();
                    chk("cmd_fields", {bus.operand_a, bus.operand_b, bus.opcode}, exp_cmd);
                end
            end
        end
        prev_valid = bus.cmd_valid;
        prev_cmd   = {bus.operand_a, bus.operand_b, bus.opcode};
    end

    initial begin
        reset          = 1'b1;
        bus.byte_data  = 8'h00;
        bus.byte_ready = 1'b0;
        bus.cmd_ready  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_a", bus.operand_a, 0);
        chk("rst_b", bus.operand_b, 0);
        chk("rst_op", bus.opcode, OP_ADD);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;

        // 12+34 CR with the calculator always ready
        mark();
        exp_q.push_back(mk(12, 34, OP_ADD));
        send_str("12+34");
        chk("t1_pre_valid", bus.cmd_valid, 0);
        send_byte(8'h0D);
        chk("t1_valid_rise", bus.cmd_valid, 1);
        @(posedge clock); #1;
        chk("t1_valid_fall", bus.cmd_valid, 0);
        chk("t1_valid_cycles", valid_cycles - base_v, 1);
        chk("t1_no_error", err_pulses - base_e, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // " 7 * 6" LF with back-pressure for 10 cycles
        mark();
        bus.cmd_ready = 1'b0;
        exp_q.push_back(mk(7, 6, OP_MUL));
        send_str(" 7 * 6");
        send_byte(8'h0A);
        chk("t2_valid_rise", bus.cmd_valid, 1);
        repeat (10) begin @(posedge clock); #1; end
        chk("t2_valid_held", bus.cmd_valid, 1);
        bus.cmd_ready = 1'b1;
        @(posedge clock); #1;
        chk("t2_valid_fall", bus.cmd_valid, 0);
        chk("t2_valid_cycles", valid_cycles - base_v, 11);
        chk("t2_hs", hs_cnt - base_h, 1);
        chk("t2_no_error", err_pulses - base_e, 0);

        // Six-digit operand, then a clean division
        mark();
        send_str("12345");
        chk("t3_pre_err", bus.error, 0);
        send_byte("6");
        chk("t3_err_6th", bus.error, 1);
        chk("t3_busy_discard", bus.busy, 1);
        send_str("+1");
        send_byte(8'h0D);
        chk("t3_idle_after", bus.busy, 0);
        @(posedge clock); #1;
        chk("t3_err_count", err_pulses - base_e, 1);
        chk("t3_no_valid", valid_cycles - base_v, 0);
        exp_q.push_back(mk(5, 5, OP_DIV));
        send_str("5/5");
        send_byte(8'h0D);
        @(posedge clock); #1;
        chk("t3_hs", hs_cnt - base_h, 1);
        chk("t3_q_empty", exp_q.size(), 0);

        // Overflow truncation and the largest five-digit operand
        mark();
        exp_q.push_back(mk(4464, 1, OP_SUB));
        exp_q.push_back(mk(65535, 2, OP_MUL));
        send_str("70000-1");
        send_byte(8'h0D);
        send_str("65535*2");
        send_byte(8'h0D);
        @(posedge clock); #1;
        chk("t4_hs", hs_cnt - base_h, 2);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_no_error", err_pulses - base_e, 0);

        // Leading operator, empty line, missing operand B
        mark();
        send_byte("+");
        chk("t5_err_plus", bus.error, 1);
        send_str("3");
        send_byte(8'h0D);
        chk("t5_idle1", bus.busy, 0);
        send_byte(8'h0D);
        chk("t5_empty_no_err", bus.error, 0);
        chk("t5_empty_idle", bus.busy, 0);
        send_str("9-");
        chk("t5_busy_opb", bus.busy, 1);
        send_byte(8'h0D);
        chk("t5_err_cr", bus.error, 1);
        chk("t5_idle2", bus.busy, 0);
        exp_q.push_back(mk(1, 1, OP_ADD));
        send_str("1+1");
        send_byte(8'h0D);
        @(posedge clock); #1;
        chk("t5_err_count", err_pulses - base_e, 2);
        chk("t5_hs", hs_cnt - base_h, 1);
        chk("t5_q_empty", exp_q.size(), 0);

        // Asynchronous reset mid-frame, then a byte dropped during HOLD
        mark();
        send_str("12");
        chk("t6_a_partial", bus.operand_a, 12);
        chk("t6_busy_partial", bus.busy, 1);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_a", bus.operand_a, 0);
        chk("t6_rst_b", bus.operand_b, 0);
        chk("t6_rst_op", bus.opcode, OP_ADD);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_valid", bus.cmd_valid, 0);
        chk("t6_rst_error", bus.error, 0);
        #1 reset = 1'b0;
        bus.cmd_ready = 1'b0;
        exp_q.push_back(mk(1, 2, OP_ADD));
        send_str("1+2");
        send_byte(8'h0D);
        chk("t6_valid", bus.cmd_valid, 1);
        send_byte("x");
        chk("t6_hold_err", bus.error, 1);
        chk("t6_hold_valid", bus.cmd_valid, 1);
        chk("t6_hold_a", bus.operand_a, 1);
        chk("t6_hold_b", bus.operand_b, 2);
        bus.cmd_ready  = 1'b1;
        bus.byte_data  = "z";
        bus.byte_ready = 1'b1;
        @(posedge clock); #1;
        bus.byte_ready = 1'b0;
        chk("t6_hs_err", bus.error, 1);
        chk("t6_hs_valid_fall", bus.cmd_valid, 0);
        chk("t6_hs_idle", bus.busy, 0);
        @(posedge clock); #1;
        chk("t6_err_count", err_pulses - base_e, 2);
        chk("t6_hs", hs_cnt - base_h, 1);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
